// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control-bundle layout, register constants and
// the ID/EX payload struct.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 12;

  // Control bundle field offsets (bit positions inside ctrl).
  localparam int CTRL_ALU_OP_LSB  = 0;
  localparam int CTRL_ALU_OP_W    = 4;
  localparam int CTRL_ALU_SRC     = 4;
  localparam int CTRL_MEM_WRITE   = 5;
  localparam int CTRL_BRANCH      = 6;
  localparam int CTRL_JUMP        = 7;
  localparam int CTRL_FUNCT3_LSB  = 8;
  localparam int CTRL_FUNCT3_W    = 3;
  localparam int CTRL_WB_SEL      = 11;

  localparam logic [4:0] REG_X0 = 5'd0;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic              mem_read;
    logic              reg_write;
    logic [CTRL_W-1:0] ctrl;
  } id_ex_bundle_t;

  localparam id_ex_bundle_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/load_use_detector.sv
// Combinational load-use hazard detect between the ID instruction and the
// load currently held in EX.
import pipe_pkg::*;

module load_use_detector (
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  output logic       lu
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

  // x0 is hardwired zero, so a load targeting it never produces a dependency.
  assign lu = id_valid && ex_valid && ex_mem_read && (ex_rd != REG_X0) &&
              (rs1_hit || rs2_hit);

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion, EX hold and flush.
// Define HAZARD_STATS_EN to add the stall_cycles / flush_count counters.
import pipe_pkg::*;

module id_ex_stage_reg #(
  parameter int XLEN   = pipe_pkg::XLEN,
  parameter int CTRL_W = pipe_pkg::CTRL_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_rs1_data,
  input  logic [XLEN-1:0]   id_rs2_data,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              ex_hold,
  input  logic              flush,
  output logic              ID_EX_valid,
  output logic [XLEN-1:0]   ID_EX_pc,
  output logic [XLEN-1:0]   ID_EX_rs1_data,
  output logic [XLEN-1:0]   ID_EX_rs2_data,
  output logic [XLEN-1:0]   ID_EX_imm,
  output logic [4:0]        ID_EX_rs1,
  output logic [4:0]        ID_EX_rs2,
  output logic [4:0]        ID_EX_rd,
  output logic              ID_EX_mem_read,
  output logic              ID_EX_reg_write,
  output logic [CTRL_W-1:0] ID_EX_ctrl,
`ifdef HAZARD_STATS_EN
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count,
`endif
  output logic              stall_if_id
);

  id_ex_bundle_t id_d;
  id_ex_bundle_t ex_q;
  logic          valid_q;
  logic          lu;

  always_comb begin
    id_d           = ID_EX_BUBBLE;
    id_d.pc        = id_pc;
    id_d.rs1_data  = id_rs1_data;
    id_d.rs2_data  = id_rs2_data;
    id_d.imm       = id_imm;
    id_d.rs1       = id_rs1;
    id_d.rs2       = id_rs2;
    id_d.rd        = id_rd;
    id_d.mem_read  = id_mem_read;
    id_d.reg_write = id_reg_write;
    id_d.ctrl      = id_ctrl;
  end

  load_use_detector u_lu (
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_valid    (valid_q),
    .ex_mem_read (ex_q.mem_read),
    .ex_rd       (ex_q.rd),
    .lu          (lu)
  );

  // Flow control: ex_hold is EX's "not ready" (nothing moves while high);
  // stall_if_id is this stage's "not ready" back to IF/ID and the PC. A flush
  // overrides both because the ID instruction is being discarded anyway.
  assign stall_if_id = (lu || ex_hold) && !flush;

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      valid_q <= 1'b0;
      ex_q    <= ID_EX_BUBBLE;
    end else if (ex_hold) begin
      valid_q <= valid_q;
      ex_q    <= ex_q;
    end else if (lu || !id_valid) begin
      valid_q <= 1'b0;
      ex_q    <= ID_EX_BUBBLE;
    end else begin
      valid_q <= 1'b1;
      ex_q    <= id_d;
    end
  end

  assign ID_EX_valid     = valid_q;
  assign ID_EX_pc        = ex_q.pc;
  assign ID_EX_rs1_data  = ex_q.rs1_data;
  assign ID_EX_rs2_data  = ex_q.rs2_data;
  assign ID_EX_imm       = ex_q.imm;
  assign ID_EX_rs1       = ex_q.rs1;
  assign ID_EX_rs2       = ex_q.rs2;
  assign ID_EX_rd        = ex_q.rd;
  assign ID_EX_mem_read  = ex_q.mem_read;
  assign ID_EX_reg_write = ex_q.reg_write;
  assign ID_EX_ctrl      = ex_q.ctrl;

`ifdef HAZARD_STATS_EN
  // Saturating counters: they stop at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (stall_if_id && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (flush && (flush_count != 32'hFFFF_FFFF))
        flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Self-checking bench for id_ex_stage_reg: directed hazard scenarios plus
// randomized traffic compared every cycle against a behavioural slot model.
module tb_id_ex_stage_reg;

  logic        clk;
  logic        reset_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_uses_rs1, id_uses_rs2, id_mem_read, id_reg_write;
  logic [11:0] id_ctrl;
  logic        ex_hold, flush;
  logic        ID_EX_valid;
  logic [31:0] ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
  logic [4:0]  ID_EX_rs1, ID_EX_rs2, ID_EX_rd;
  logic        ID_EX_mem_read, ID_EX_reg_write;
  logic [11:0] ID_EX_ctrl;
  logic        stall_if_id;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cycles, flush_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  id_ex_stage_reg dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write), .id_ctrl(id_ctrl),
    .ex_hold(ex_hold), .flush(flush),
    .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc),
    .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
    .ID_EX_imm(ID_EX_imm), .ID_EX_rs1(ID_EX_rs1), .ID_EX_rs2(ID_EX_rs2),
    .ID_EX_rd(ID_EX_rd), .ID_EX_mem_read(ID_EX_mem_read),
    .ID_EX_reg_write(ID_EX_reg_write), .ID_EX_ctrl(ID_EX_ctrl),
`ifdef HAZARD_STATS_EN
    .stall_cycles(stall_cycles), .flush_count(flush_count),
`endif
    .stall_if_id(stall_if_id)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: the EX slot is either empty (all zero) or a copy of
  // the instruction that was accepted from ID.
  typedef struct {
    bit          valid;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs1, rs2, rd;
    bit          mr, rw;
    logic [11:0] ctrl;
  } slot_t;

  slot_t       m_slot;
  logic [31:0] m_stalls, m_flushes;

  function automatic slot_t empty_slot();
    slot_t s;
    s.valid = 0; s.pc = 0; s.a = 0; s.b = 0; s.imm = 0;
    s.rs1 = 0; s.rs2 = 0; s.rd = 0; s.mr = 0; s.rw = 0; s.ctrl = 0;
    return s;
  endfunction

  // Does the ID instruction need the value the EX load has not produced yet?
  function automatic bit needs_load_result();
    if (!id_valid || !m_slot.valid || !m_slot.mr || m_slot.rd == 0) return 0;
    return (id_uses_rs1 && id_rs1 == m_slot.rd) || (id_uses_rs2 && id_rs2 == m_slot.rd);
  endfunction

  function automatic bit exp_stall();
    return (needs_load_result() || ex_hold) && !flush;
  endfunction

  always @(posedge clk) begin
    bit st;
    st = exp_stall();
    if (!reset_n) begin
      m_slot = empty_slot();
      m_stalls = 0;
      m_flushes = 0;
    end else begin
      if (st && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
      if (flush && m_flushes != 32'hFFFF_FFFF) m_flushes = m_flushes + 1;
      if (flush) m_slot = empty_slot();
      else if (ex_hold) m_slot = m_slot;
      else if (needs_load_result() || !id_valid) m_slot = empty_slot();
      else begin
        m_slot.valid = 1; m_slot.pc = id_pc; m_slot.a = id_rs1_data;
        m_slot.b = id_rs2_data; m_slot.imm = id_imm; m_slot.rs1 = id_rs1;
        m_slot.rs2 = id_rs2; m_slot.rd = id_rd; m_slot.mr = id_mem_read;
        m_slot.rw = id_reg_write; m_slot.ctrl = id_ctrl;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare: every cycle, away from the active edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("valid", {31'd0, ID_EX_valid}, {31'd0, m_slot.valid});
      chk("pc", ID_EX_pc, m_slot.pc);
      chk("rs1_data", ID_EX_rs1_data, m_slot.a);
      chk("rs2_data", ID_EX_rs2_data, m_slot.b);
      chk("imm", ID_EX_imm, m_slot.imm);
      chk("rs1", {27'd0, ID_EX_rs1}, {27'd0, m_slot.rs1});
      chk("rs2", {27'd0, ID_EX_rs2}, {27'd0, m_slot.rs2});
      chk("rd", {27'd0, ID_EX_rd}, {27'd0, m_slot.rd});
      chk("mem_read", {31'd0, ID_EX_mem_read}, {31'd0, m_slot.mr});
      chk("reg_write", {31'd0, ID_EX_reg_write}, {31'd0, m_slot.rw});
      chk("ctrl", {20'd0, ID_EX_ctrl}, {20'd0, m_slot.ctrl});
      chk("stall_if_id", {31'd0, stall_if_id}, {31'd0, exp_stall()});
`ifdef HAZARD_STATS_EN
      chk("stall_cycles", stall_cycles, m_stalls);
      chk("flush_count", flush_count, m_flushes);
`endif
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input bit v, input logic [4:0] rs1, input bit u1,
                        input logic [4:0] rs2, input bit u2,
                        input logic [4:0] rd, input bit mr, input logic [31:0] pc);
    id_valid = v; id_rs1 = rs1; id_uses_rs1 = u1; id_rs2 = rs2; id_uses_rs2 = u2;
    id_rd = rd; id_mem_read = mr; id_reg_write = 1; id_pc = pc;
    id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_ctrl = 12'($urandom_range(1, 4095));
  endtask

  task automatic rand_cycle();
    id_valid = ($urandom_range(0, 7) != 0);
    id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
    id_rd = 5'($urandom_range(0, 3));
    id_uses_rs1 = 1'($urandom_range(0, 1)); id_uses_rs2 = 1'($urandom_range(0, 1));
    id_mem_read = ($urandom_range(0, 2) == 0); id_reg_write = 1'($urandom_range(0, 1));
    id_pc = $urandom; id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
    id_ctrl = 12'($urandom);
    ex_hold = ($urandom_range(0, 7) == 0);
    flush = ($urandom_range(0, 9) == 0);
    reset_n = ($urandom_range(0, 99) != 0);
  endtask

  initial begin
    logic [31:0] fc_before;
    reset_n = 0; ex_hold = 0; flush = 0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    check_en = 1;
    @(negedge clk);
    chk("reset_valid", {31'd0, ID_EX_valid}, 32'd0);
    chk("reset_ctrl", {20'd0, ID_EX_ctrl}, 32'd0);
    reset_n = 1;

    // Back-to-back ALU ops, no hazard
    step();
    set_id(1, 1, 1, 2, 1, 3, 0, 32'h100);
    step();
    set_id(1, 3, 1, 4, 1, 4, 0, 32'h104);
    @(negedge clk);
    chk("alu0_pc", ID_EX_pc, 32'h100);
    chk("alu0_rd", {27'd0, ID_EX_rd}, 32'd3);
    chk("alu_no_stall", {31'd0, stall_if_id}, 32'd0);
    step();
    @(negedge clk);
    chk("alu1_pc", ID_EX_pc, 32'h104);

    // lw x5 then add x6,x5,x7
    step();
    set_id(1, 2, 1, 0, 0, 5, 1, 32'h200);
    step();
    set_id(1, 5, 1, 7, 1, 6, 0, 32'h204);
    @(negedge clk);
    chk("lu_stall", {31'd0, stall_if_id}, 32'd1);
    step();
    @(negedge clk);
    chk("bubble_valid", {31'd0, ID_EX_valid}, 32'd0);
    chk("bubble_rd", {27'd0, ID_EX_rd}, 32'd0);
    chk("bubble_ctrl", {20'd0, ID_EX_ctrl}, 32'd0);
    chk("lu_one_cycle", {31'd0, stall_if_id}, 32'd0);
    step();
    @(negedge clk);
    chk("add_enters_rd", {27'd0, ID_EX_rd}, 32'd6);
    chk("add_enters_pc", ID_EX_pc, 32'h204);

    // lw x0 with ID reading x0; lw x5 with rs2=5 unused
    step();
    set_id(1, 1, 1, 0, 0, 0, 1, 32'h300);
    step();
    set_id(1, 0, 1, 0, 1, 8, 0, 32'h304);
    @(negedge clk);
    chk("x0_no_stall", {31'd0, stall_if_id}, 32'd0);
    step();
    set_id(1, 1, 1, 0, 0, 5, 1, 32'h308);
    step();
    set_id(1, 1, 1, 5, 0, 8, 0, 32'h30c);
    @(negedge clk);
    chk("unused_rs2_no_stall", {31'd0, stall_if_id}, 32'd0);

    // ex_hold for 3 cycles
    step();
    set_id(1, 1, 1, 2, 1, 9, 0, 32'h400);
    step();
    ex_hold = 1;
    set_id(1, 1, 1, 2, 1, 10, 0, 32'h404);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_pc", ID_EX_pc, 32'h400);
      chk("hold_stall", {31'd0, stall_if_id}, 32'd1);
      step();
    end
    ex_hold = 0;

    // flush while ex_hold and lu both high
    set_id(1, 1, 1, 0, 0, 5, 1, 32'h500);
    step();
    set_id(1, 5, 1, 0, 0, 6, 0, 32'h504);
    ex_hold = 1; flush = 1;
`ifdef HAZARD_STATS_EN
    fc_before = flush_count;
`else
    fc_before = 0;
`endif
    @(negedge clk);
    chk("flush_no_stall", {31'd0, stall_if_id}, 32'd0);
    step();
    ex_hold = 0; flush = 0;
    @(negedge clk);
    chk("flush_bubble", {31'd0, ID_EX_valid}, 32'd0);
`ifdef HAZARD_STATS_EN
    chk("flush_count_inc", flush_count, fc_before + 32'd1);
`endif

    // reset during a hold
    step();
    set_id(1, 1, 1, 2, 1, 11, 0, 32'h600);
    step();
    ex_hold = 1;
    step();
    reset_n = 0;
    step();
    reset_n = 1;
    @(negedge clk);
    chk("rst_hold_valid", {31'd0, ID_EX_valid}, 32'd0);
    chk("rst_hold_pc", ID_EX_pc, 32'd0);
`ifdef HAZARD_STATS_EN
    chk("rst_hold_cnt", stall_cycles, 32'd0);
`endif
    ex_hold = 0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rand_cycle();
    end
    step();
    reset_n = 1; ex_hold = 0; flush = 0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
